prf_write_arbiter: RTL and testbench

Arbiter and sequencer for the single write port of `physical_register_file`. Two writeback requesters compete for that port: A is the ALU result path and B is the load/immediate path. The block grants one request per cycle with round-robin fairness and registers the winning write one cycle before it drives the port. It drops writes to register 0 and returns bypass hits so read-side logic sees a value that is accepted but not yet committed.

---
 rtl/prf_write_arbiter.sv | 110 +++++++++++
 tb/tb_prf_write_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/prf_write_arbiter.sv
// prf_write_arbiter
//   Round-robin arbiter for the single write port of physical_register_file.
//   Requester A (ALU results) and requester B (loads/immediates) compete for
//   one grant per cycle. The winning write is registered for one cycle before
//   it drives the PRF write port. Writes to register 0 are accepted but
//   dropped. Bypass hits let read-side logic see the in-flight value.
//
// Ports
//   clk, arst_n              clock, asynchronous active-low reset
//   hold                     stall; blocks new acceptances only
//   a_valid/a_dir/a_data     requester A write request
//   a_ready                  A accepted this cycle (combinational)
//   b_valid/b_dir/b_data     requester B write request
//   b_ready                  B accepted this cycle (combinational)
//   write_en/dir/data        registered PRF write port drive
//   read_dir1, read_dir2     PRF read addresses, used for bypass compare
//   byp_hit1, byp_hit2       read port N must take byp_data
//   byp_data                 in-flight write data (equals write_data)
//   last_grant               most recent acceptance: 0 = A, 1 = B
module prf_write_arbiter #(
  parameter int DIR_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  hold,
  input  logic                  a_valid,
  input  logic [DIR_WIDTH-1:0]  a_dir,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [DIR_WIDTH-1:0]  b_dir,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  write_en,
  output logic [DIR_WIDTH-1:0]  write_dir,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DIR_WIDTH-1:0]  read_dir1,
  input  logic [DIR_WIDTH-1:0]  read_dir2,
  output logic                  byp_hit1,
  output logic                  byp_hit2,
  output logic [DATA_WIDTH-1:0] byp_data,
  output logic                  last_grant
);

  // prio_q: 0 favours A, 1 favours B.
  logic                  prio_q, prio_d;
  logic                  last_grant_q, last_grant_d;
  logic                  write_en_q, write_en_d;
  logic [DIR_WIDTH-1:0]  write_dir_q, write_dir_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

  logic grant_a, grant_b, xfer;
  logic [DIR_WIDTH-1:0]  sel_dir;
  logic [DATA_WIDTH-1:0] sel_data;

  // Grant: a lone requester always wins; on a tie the prio requester wins.
  assign grant_a = !hold && a_valid && (!b_valid || !prio_q);
  assign grant_b = !hold && b_valid && (!a_valid ||  prio_q);
  assign xfer    = grant_a || grant_b;
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign sel_dir  = grant_b ? b_dir  : a_dir;
  assign sel_data = grant_b ? b_data : a_data;

  always_comb begin
    prio_d       = prio_q;
    last_grant_d = last_grant_q;
    write_dir_d  = write_dir_q;
    write_data_d = write_data_q;
    // write_en is a one-cycle pulse per accepted write; register 0 is dropped.
    write_en_d   = xfer && (sel_dir != '0);
    if (xfer) begin
      // The winner moves to lowest priority, even if it was alone.
      prio_d       = !grant_b;
      last_grant_d = grant_b;
      write_dir_d  = sel_dir;
      write_data_d = sel_data;
    end
  end

  // ---- registered write stage ----
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      prio_q       <= 1'b0;
      last_grant_q <= 1'b0;
      write_en_q   <= 1'b0;
      write_dir_q  <= '0;
      write_data_q <= '0;
    end else begin
      prio_q       <= prio_d;
      last_grant_q <= last_grant_d;
      write_en_q   <= write_en_d;
      write_dir_q  <= write_dir_d;
      write_data_q <= write_data_d;
    end
  end

  assign write_en   = write_en_q;
  assign write_dir  = write_dir_q;
  assign write_data = write_data_q;
  assign last_grant = last_grant_q;

  // Bypass from the registered stage; register 0 never hits.
  assign byp_hit1 = write_en_q && (write_dir_q == read_dir1) && (read_dir1 != '0);
  assign byp_hit2 = write_en_q && (write_dir_q == read_dir2) && (read_dir2 != '0);
  assign byp_data = write_data_q;

endmodule

// File: tb/tb_prf_write_arbiter.sv
// Directed testbench for prf_write_arbiter. A small behavioural PRF array
// is written from the DUT write port so committed values can be checked.
module tb_prf_write_arbiter;

  localparam int DW = 5;
  localparam int XW = 32;

  logic          clk;
  logic          arst_n;
  logic          hold;
  logic          a_valid, b_valid;
  logic [DW-1:0] a_dir, b_dir;
  logic [XW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          write_en;
  logic [DW-1:0] write_dir;
  logic [XW-1:0] write_data;
  logic [DW-1:0] read_dir1, read_dir2;
  logic          byp_hit1, byp_hit2;
  logic [XW-1:0] byp_data;
  logic          last_grant;

  int nvec = 0;
  int nerr = 0;

  logic [XW-1:0] prf [32];

  prf_write_arbiter #(.DIR_WIDTH(DW), .DATA_WIDTH(XW)) dut (
    .clk(clk), .arst_n(arst_n), .hold(hold),
    .a_valid(a_valid), .a_dir(a_dir), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_dir(b_dir), .b_data(b_data), .b_ready(b_ready),
    .write_en(write_en), .write_dir(write_dir), .write_data(write_data),
    .read_dir1(read_dir1), .read_dir2(read_dir2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data(byp_data),
    .last_grant(last_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 32; i++) prf[i] = '0;
  end

  always @(posedge clk) begin
    if (write_en) prf[write_dir] <= write_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n    = 1'b0;
    hold      = 1'b0;
    a_valid   = 1'b1; a_dir = 5'd1; a_data = 32'h11;
    b_valid   = 1'b1; b_dir = 5'd2; b_data = 32'h22;
    read_dir1 = 5'd1; read_dir2 = 5'd2;
    #2;
    chk("rst_we",    write_en,   0);
    chk("rst_dir",   write_dir,  0);
    chk("rst_data",  write_data, 0);
    chk("rst_lg",    last_grant, 0);
    chk("rst_hit1",  byp_hit1,   0);
    chk("rst_hit2",  byp_hit2,   0);
    tick();
    #5 arst_n = 1'b1;
    #1;
    // cycle 0: tie, prio = A
    chk("c0_a_rdy", a_ready, 1);
    chk("c0_b_rdy", b_ready, 0);
    tick();
    a_valid = 1'b0;
    #1;
    // cycle 1: A's write in flight, B now favoured
    chk("c1_we",    write_en,   1);
    chk("c1_dir",   write_dir,  1);
    chk("c1_data",  write_data, 32'h11);
    chk("c1_lg",    last_grant, 0);
    chk("c1_hit1",  byp_hit1,   1);
    chk("c1_b_rdy", b_ready,    1);
    tick();
    b_valid = 1'b0;
    #1;
    chk("c2_we",   write_en,   1);
    chk("c2_dir",  write_dir,  2);
    chk("c2_data", write_data, 32'h22);
    chk("c2_lg",   last_grant, 1);
    chk("c2_hit2", byp_hit2,   1);
    chk("c2_hit1", byp_hit1,   0);

    // A only, 4 consecutive writes
    a_valid = 1'b1; a_dir = 5'd3; a_data = 32'h5;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("aonly_rdy", a_ready, 1);
      tick();
      if (i == 3) a_valid = 1'b0;
      #1;
      chk("aonly_we",   write_en,   1);
      chk("aonly_dir",  write_dir,  3);
      chk("aonly_data", write_data, 32'h5);
      chk("aonly_lg",   last_grant, 0);
    end
    tick();
    chk("idle_we",  write_en,  0);
    chk("idle_dir", write_dir, 3);
    chk("prf3",     prf[3],    32'h5);

    // write to register 0
    a_valid = 1'b1; a_dir = 5'd0; a_data = 32'hDEADBEEF; read_dir1 = 5'd0;
    #1;
    chk("r0_rdy", a_ready, 1);
    tick();
    a_valid = 1'b0;
    #1;
    chk("r0_we",   write_en,   0);
    chk("r0_dir",  write_dir,  0);
    chk("r0_data", write_data, 32'hDEADBEEF);
    chk("r0_hit1", byp_hit1,   0);
    tick();
    chk("r0_prf", prf[0], 0);

    // bypass window
    a_valid = 1'b1; a_dir = 5'd7; a_data = 32'h15;
    #1;
    tick();
    a_valid = 1'b0; read_dir1 = 5'd7; read_dir2 = 5'd3;
    #1;
    chk("byp_hit1", byp_hit1, 1);
    chk("byp_hit2", byp_hit2, 0);
    chk("byp_data", byp_data, 32'h15);
    tick();
    chk("byp_hit1_n2", byp_hit1, 0);
    chk("byp_prf7",    prf[7],   32'h15);

    // hold with both valid; last winner was A so B is favoured
    hold = 1'b1;
    a_valid = 1'b1; a_dir = 5'd4; a_data = 32'h44;
    b_valid = 1'b1; b_dir = 5'd5; b_data = 32'h55;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_a_rdy", a_ready, 0);
      chk("hold_b_rdy", b_ready, 0);
      tick();
      chk("hold_we", write_en, 0);
    end
    hold = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("alt_b_rdy", b_ready, (i % 2 == 0) ? 1 : 0);
      chk("alt_a_rdy", a_ready, (i % 2 == 0) ? 0 : 1);
      tick();
      #1;
      chk("alt_we",  write_en,   1);
      chk("alt_lg",  last_grant, (i % 2 == 0) ? 1 : 0);
      chk("alt_dir", write_dir,  (i % 2 == 0) ? 5 : 4);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // async reset right after an accept by A (prio then favours B)
    a_valid = 1'b1; a_dir = 5'd9; a_data = 32'h99; read_dir1 = 5'd9;
    #1;
    tick();
    a_valid = 1'b0;
    #1;
    chk("pre_rst_we",   write_en, 1);
    chk("pre_rst_hit1", byp_hit1, 1);
    arst_n = 1'b0;
    #1;
    chk("ar_we",   write_en,   0);
    chk("ar_dir",  write_dir,  0);
    chk("ar_data", write_data, 0);
    chk("ar_lg",   last_grant, 0);
    chk("ar_hit1", byp_hit1,   0);
    arst_n = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("ar_prio_a", a_ready, 1);
    chk("ar_prio_b", b_ready, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
